// File: rtl/stopwatch_ctrl_pkg.sv
// Shared state encoding for the stopwatch controller and anything decoding state_o.
package stopwatch_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_LAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // States in which divider ticks advance the counter.
  function automatic logic is_counting(state_e s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button/tick inputs and counter/divider/display controls of the stopwatch controller.
interface stopwatch_ctrl_if;
  import stopwatch_ctrl_pkg::*;

  logic               slow_en;
  logic               btn_start;
  logic               btn_lap;
  logic               btn_clear;
  logic               cnt_max;
  logic               cnt_en;
  logic               cnt_clr;
  logic               div_rst;
  logic               disp_follow;
  logic               done;
  logic [STATE_W-1:0] state_o;

  // Surrounding logic: drives buttons/tick/terminal flag, consumes controls.
  modport master (
    output slow_en, btn_start, btn_lap, btn_clear, cnt_max,
    input  cnt_en, cnt_clr, div_rst, disp_follow, done, state_o
  );

  // The controller itself.
  modport slave (
    input  slow_en, btn_start, btn_lap, btn_clear, cnt_max,
    output cnt_en, cnt_clr, div_rst, disp_follow, done, state_o
  );

endinterface

// File: rtl/stopwatch_ctrl_btn_edge.sv
// Rising-edge detector for one synchronized button level.
// History resets to 1 so a button held through reset produces no event.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic ev
);

  logic prev_q;

  // Register the previous button level every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= btn;
  end

  assign ev = btn & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear sequencer for the BCD stopwatch datapath.
//
// state | meaning
// IDLE  | stopped, counter holds or was cleared
// RUN   | counting on divider ticks, display follows counter
// PAUSE | stopped mid-run, counter holds
// LAP   | counting continues, display frozen
// DONE  | terminal value reached (WRAP=0), waits for clear
module stopwatch_ctrl #(
  parameter bit WRAP    = 1'b0,
  parameter int STATE_W = stopwatch_ctrl_pkg::STATE_W
) (
  input  logic                   clk,
  input  logic                   rst,
  stopwatch_ctrl_if.slave        bus
);
  import stopwatch_ctrl_pkg::*;

  logic   ev_start;
  logic   ev_lap;
  logic   ev_clear;

  state_e state_q, state_d;
  logic   cnt_en_q, cnt_en_d;
  logic   cnt_clr_q, cnt_clr_d;
  logic   div_rst_q, div_rst_d;
  logic   done_q, done_d;
  logic   disp_follow_q, disp_follow_d;
  logic   ev_taken;

  btn_edge u_edge_start (.clk(clk), .rst(rst), .btn(bus.btn_start), .ev(ev_start));
  btn_edge u_edge_lap   (.clk(clk), .rst(rst), .btn(bus.btn_lap),   .ev(ev_lap));
  btn_edge u_edge_clear (.clk(clk), .rst(rst), .btn(bus.btn_clear), .ev(ev_clear));

  // Next state and next registered outputs; clear > start > lap, accepted events eat the tick.
  always_comb begin
    state_d       = state_q;
    cnt_en_d      = 1'b0;
    cnt_clr_d     = 1'b0;
    div_rst_d     = 1'b0;
    done_d        = 1'b0;
    disp_follow_d = disp_follow_q;
    ev_taken      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ev_clear) begin
          cnt_clr_d     = 1'b1;
          disp_follow_d = 1'b1;
        end else if (ev_start) begin
          state_d       = ST_RUN;
          div_rst_d     = 1'b1;
          disp_follow_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (ev_clear) begin
          state_d   = ST_IDLE;
          cnt_clr_d = 1'b1;
          ev_taken  = 1'b1;
        end else if (ev_start) begin
          state_d  = ST_PAUSE;
          ev_taken = 1'b1;
        end else if (ev_lap) begin
          state_d       = ST_LAP;
          disp_follow_d = 1'b0;
          ev_taken      = 1'b1;
        end
      end
      ST_LAP: begin
        if (ev_clear) begin
          state_d       = ST_IDLE;
          cnt_clr_d     = 1'b1;
          disp_follow_d = 1'b1;
          ev_taken      = 1'b1;
        end else if (ev_start) begin
          state_d       = ST_PAUSE;
          disp_follow_d = 1'b1;
          ev_taken      = 1'b1;
        end else if (ev_lap) begin
          state_d       = ST_RUN;
          disp_follow_d = 1'b1;
          ev_taken      = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (ev_clear) begin
          state_d   = ST_IDLE;
          cnt_clr_d = 1'b1;
        end else if (ev_start) begin
          // Restart the divider so the first tick after resume is a full period.
          state_d   = ST_RUN;
          div_rst_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (ev_clear) begin
          state_d   = ST_IDLE;
          cnt_clr_d = 1'b1;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        disp_follow_d = 1'b1;
      end
    endcase

    if (is_counting(state_q) && bus.slow_en && !ev_taken) begin
      if (bus.cnt_max && !WRAP) begin
        state_d       = ST_DONE;
        done_d        = 1'b1;
        disp_follow_d = 1'b1;
      end else begin
        cnt_en_d = 1'b1;
      end
    end
  end

  // State and all outputs are registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_en_q      <= 1'b0;
      cnt_clr_q     <= 1'b0;
      div_rst_q     <= 1'b0;
      done_q        <= 1'b0;
      disp_follow_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_en_q      <= cnt_en_d;
      cnt_clr_q     <= cnt_clr_d;
      div_rst_q     <= div_rst_d;
      done_q        <= done_d;
      disp_follow_q <= disp_follow_d;
    end
  end

  assign bus.cnt_en      = cnt_en_q;
  assign bus.cnt_clr     = cnt_clr_q;
  assign bus.div_rst     = div_rst_q;
  assign bus.done        = done_q;
  assign bus.disp_follow = disp_follow_q;
  assign bus.state_o     = STATE_W'(state_q);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench: stimulus queues each expected output pulse, monitors pop and compare.
module tb_stopwatch_ctrl;

  typedef struct packed {
    logic       en;
    logic       clr;
    logic       drst;
    logic       dn;
    logic       fol;
    logic [2:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t got0, got1, e0, e1;

  stopwatch_ctrl_if if0 ();
  stopwatch_ctrl_if if1 ();

  stopwatch_ctrl #(.WRAP(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  stopwatch_ctrl #(.WRAP(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  function automatic exp_t mk(logic en, logic clr, logic drst, logic dn, logic fol, logic [2:0] st);
    return {en, clr, drst, dn, fol, st};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", name, act, req);
    end
  endtask

  task automatic drv(input logic s, input logic l, input logic c, input logic e, input logic m);
    @(negedge clk);
    if0.btn_start = s; if0.btn_lap = l; if0.btn_clear = c; if0.slow_en = e; if0.cnt_max = m;
  endtask

  task automatic drv1(input logic s, input logic l, input logic c, input logic e, input logic m);
    @(negedge clk);
    if1.btn_start = s; if1.btn_lap = l; if1.btn_clear = c; if1.slow_en = e; if1.cnt_max = m;
  endtask

  // Monitor for the WRAP=0 instance: every pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && (if0.cnt_en || if0.cnt_clr || if0.div_rst || if0.done)) begin
      got0 = {if0.cnt_en, if0.cnt_clr, if0.div_rst, if0.done, if0.disp_follow, if0.state_o};
      tests++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL dut0_unexpected_pulse got=%b expected=none", got0);
      end else begin
        e0 = q0.pop_front();
        if (got0 !== e0) begin
          fails++;
          $display("FAIL dut0_pulse got=%b expected=%b", got0, e0);
        end
      end
    end
  end

  // Monitor for the WRAP=1 instance.
  always @(negedge clk) begin
    if (!rst && (if1.cnt_en || if1.cnt_clr || if1.div_rst || if1.done)) begin
      got1 = {if1.cnt_en, if1.cnt_clr, if1.div_rst, if1.done, if1.disp_follow, if1.state_o};
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL dut1_unexpected_pulse got=%b expected=none", got1);
      end else begin
        e1 = q1.pop_front();
        if (got1 !== e1) begin
          fails++;
          $display("FAIL dut1_pulse got=%b expected=%b", got1, e1);
        end
      end
    end
  end

  initial begin
    if0.btn_start = 1'b1; if0.btn_lap = 1'b0; if0.btn_clear = 1'b0; if0.slow_en = 1'b0; if0.cnt_max = 1'b0;
    if1.btn_start = 1'b0; if1.btn_lap = 1'b0; if1.btn_clear = 1'b0; if1.slow_en = 1'b0; if1.cnt_max = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 8'(if0.state_o), 8'd0);
    chk("rst_follow", 8'(if0.disp_follow), 8'd1);
    chk("rst_cnt_en", 8'(if0.cnt_en), 8'd0);
    chk("rst_div_rst", 8'(if0.div_rst), 8'd0);
    rst = 1'b0;

    // Start held through reset: no event.
    repeat (3) drv(1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    chk("held_no_event", 8'(if0.state_o), 8'd0);

    // Press start: RUN with one div_rst pulse.
    drv(1, 0, 0, 0, 0); q0.push_back(mk(0, 0, 1, 0, 1, 3'd1));
    drv(0, 0, 0, 0, 0);
    chk("start_run", 8'(if0.state_o), 8'd1);

    // Five ticks -> five cnt_en pulses.
    for (int i = 0; i < 5; i++) begin
      drv(0, 0, 0, 1, 0); q0.push_back(mk(1, 0, 0, 0, 1, 3'd1));
      drv(0, 0, 0, 0, 0);
    end

    // Pause: ticks ignored.
    drv(1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    chk("pause_state", 8'(if0.state_o), 8'd2);
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 1, 0);
      drv(0, 0, 0, 0, 0);
    end
    drv(0, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    chk("pause_lap_ignored", 8'(if0.state_o), 8'd2);

    // Resume from PAUSE restarts divider.
    drv(1, 0, 0, 0, 0); q0.push_back(mk(0, 0, 1, 0, 1, 3'd1));
    drv(0, 0, 0, 0, 0);

    // Lap: display frozen, counting continues.
    drv(0, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    chk("lap_state", 8'(if0.state_o), 8'd3);
    chk("lap_follow", 8'(if0.disp_follow), 8'd0);
    drv(0, 0, 0, 1, 0); q0.push_back(mk(1, 0, 0, 0, 0, 3'd3));
    drv(0, 0, 0, 0, 0);
    drv(0, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    chk("unlap_state", 8'(if0.state_o), 8'd1);
    chk("unlap_follow", 8'(if0.disp_follow), 8'd1);

    // Event coinciding with tick suppresses the tick.
    drv(0, 1, 0, 1, 0);
    drv(0, 0, 0, 0, 0);
    chk("lap_tick_collide", 8'(if0.state_o), 8'd3);
    drv(0, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0);

    // Clear and start together in RUN: clear wins.
    drv(1, 0, 1, 1, 0); q0.push_back(mk(0, 1, 0, 0, 1, 3'd0));
    drv(0, 0, 0, 0, 0);
    chk("clear_prio_state", 8'(if0.state_o), 8'd0);

    // IDLE: clear pulses, lap ignored.
    drv(0, 0, 1, 0, 0); q0.push_back(mk(0, 1, 0, 0, 1, 3'd0));
    drv(0, 0, 0, 0, 0);
    drv(0, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    chk("idle_lap_ignored", 8'(if0.state_o), 8'd0);

    // Terminal value with WRAP=0 -> DONE.
    drv(1, 0, 0, 0, 0); q0.push_back(mk(0, 0, 1, 0, 1, 3'd1));
    drv(0, 0, 0, 0, 0);
    drv(0, 0, 0, 1, 1); q0.push_back(mk(0, 0, 0, 1, 1, 3'd4));
    drv(0, 0, 0, 0, 0);
    chk("done_state", 8'(if0.state_o), 8'd4);
    drv(1, 0, 0, 1, 1);
    drv(0, 0, 0, 0, 0);
    chk("done_start_ignored", 8'(if0.state_o), 8'd4);
    drv(0, 0, 1, 0, 0); q0.push_back(mk(0, 1, 0, 0, 1, 3'd0));
    drv(0, 0, 0, 0, 0);
    chk("done_clear_idle", 8'(if0.state_o), 8'd0);

    // Clear from LAP restores display follow.
    drv(1, 0, 0, 0, 0); q0.push_back(mk(0, 0, 1, 0, 1, 3'd1));
    drv(0, 0, 0, 0, 0);
    drv(0, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    drv(0, 0, 1, 0, 0); q0.push_back(mk(0, 1, 0, 0, 1, 3'd0));
    drv(0, 0, 0, 0, 0);

    // Async reset mid-run.
    drv(1, 0, 0, 0, 0); q0.push_back(mk(0, 0, 1, 0, 1, 3'd1));
    drv(0, 0, 0, 0, 0);
    drv(0, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("midrun_rst_state", 8'(if0.state_o), 8'd0);
    chk("midrun_rst_follow", 8'(if0.disp_follow), 8'd1);
    @(negedge clk); rst = 1'b0;

    // WRAP=1 instance: terminal value keeps counting.
    drv1(1, 0, 0, 0, 0); q1.push_back(mk(0, 0, 1, 0, 1, 3'd1));
    drv1(0, 0, 0, 0, 0);
    drv1(0, 0, 0, 1, 1); q1.push_back(mk(1, 0, 0, 0, 1, 3'd1));
    drv1(0, 0, 0, 0, 0);
    chk("wrap_state_run", 8'(if1.state_o), 8'd1);
    chk("wrap_no_done", 8'(if1.done), 8'd0);
    drv1(0, 0, 1, 0, 0); q1.push_back(mk(0, 1, 0, 0, 1, 3'd0));
    drv1(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    chk("q0_drained", 8'(q0.size()), 8'd0);
    chk("q1_drained", 8'(q1.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
